// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: operand fetch with EX/MEM/WB forwarding, load-use stall and ID/EX register
module id_ex_operand_stage #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [3:0]        id_sa,
  input  logic [3:0]        id_sb,
  input  logic [3:0]        id_sd,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_use_d,
  input  logic [3:0]        id_dest,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  output logic [3:0]        SA,
  output logic [3:0]        SB,
  output logic [3:0]        SD,
  input  logic [31:0]       PA,
  input  logic [31:0]       PB,
  input  logic [31:0]       PD,
  input  logic [31:0]       ex_result,
  input  logic [3:0]        mem_dest,
  input  logic              mem_wr_en,
  input  logic [31:0]       mem_result,
  input  logic [3:0]        wb_dest,
  input  logic              wb_wr_en,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [31:0]       ex_d,
  output logic [3:0]        ex_dest,
  output logic              ex_wr_en,
  output logic              ex_is_load,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [31:0] fwd_a, fwd_b, fwd_d;
  logic        ex_fwd, hit;

  function automatic logic [31:0] pick(input logic [3:0] s, input logic [31:0] p, input logic ex_ok,
                                       input logic [3:0] ed, input logic [31:0] er,
                                       input logic mw, input logic [3:0] md, input logic [31:0] mr,
                                       input logic ww, input logic [3:0] wd, input logic [31:0] wr);
    return (s == 4'd15) ? p :
           (ex_ok && ed == s) ? er :
           (mw && md == s) ? mr :
           (ww && wd == s) ? wr : p;
  endfunction

  assign SA = id_sa;
  assign SB = id_sb;
  assign SD = id_sd;

  // a load in EX has no result yet, so it is excluded from EX forwarding and handled by the stall
  always_comb begin
    ex_fwd = ex_valid && ex_wr_en && !ex_is_load;
    fwd_a  = pick(id_sa, PA, ex_fwd, ex_dest, ex_result, mem_wr_en, mem_dest, mem_result, wb_wr_en, wb_dest, wb_data);
    fwd_b  = pick(id_sb, PB, ex_fwd, ex_dest, ex_result, mem_wr_en, mem_dest, mem_result, wb_wr_en, wb_dest, wb_data);
    fwd_d  = pick(id_sd, PD, ex_fwd, ex_dest, ex_result, mem_wr_en, mem_dest, mem_result, wb_wr_en, wb_dest, wb_data);
    hit    = (id_use_a && id_sa == ex_dest) || (id_use_b && id_sb == ex_dest) || (id_use_d && id_sd == ex_dest);
    stall  = id_valid && !flush && ex_valid && ex_is_load && ex_wr_en && ex_dest != 4'd15 && hit;
  end

  always_ff @(posedge CLK) begin
    if (RST || flush || stall) begin
      ex_valid   <= 1'b0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_d       <= '0;
      ex_dest    <= '0;
      ex_wr_en   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_ctrl    <= '0;
    end else begin
      ex_valid   <= id_valid;
      ex_a       <= fwd_a;
      ex_b       <= fwd_b;
      ex_d       <= fwd_d;
      ex_dest    <= id_dest;
      ex_wr_en   <= id_wr_en && id_valid;
      ex_is_load <= id_is_load && id_valid;
      ex_ctrl    <= id_ctrl;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) stall_cnt <= '0;
    else if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed checks of forwarding priority, load-use stall, flush and R15 rules
module tb_id_ex_operand_stage;
  logic        CLK = 0, RST;
  logic        id_valid, id_use_a, id_use_b, id_use_d, id_wr_en, id_is_load;
  logic [3:0]  id_sa, id_sb, id_sd, id_dest, SA, SB, SD, mem_dest, wb_dest, ex_dest;
  logic [15:0] id_ctrl, ex_ctrl, stall_cnt;
  logic [31:0] PA, PB, PD, ex_result, mem_result, wb_data, ex_a, ex_b, ex_d;
  logic        mem_wr_en, wb_wr_en, flush, stall, ex_valid, ex_wr_en, ex_is_load;
  int          total = 0, bad = 0;

  always #5 CLK = ~CLK;

  id_ex_operand_stage dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_sa(id_sa), .id_sb(id_sb), .id_sd(id_sd),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_d(id_use_d), .id_dest(id_dest),
    .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_ctrl(id_ctrl), .SA(SA), .SB(SB), .SD(SD),
    .PA(PA), .PB(PB), .PD(PD), .ex_result(ex_result), .mem_dest(mem_dest), .mem_wr_en(mem_wr_en),
    .mem_result(mem_result), .wb_dest(wb_dest), .wb_wr_en(wb_wr_en), .wb_data(wb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_d(ex_d),
    .ex_dest(ex_dest), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1; flush = 0;
    id_valid = 1; id_sa = 4'd7; id_sb = 4'd3; id_sd = 4'd9; id_use_a = 1; id_use_b = 1; id_use_d = 1;
    id_dest = 4'd5; id_wr_en = 1; id_is_load = 1; id_ctrl = 16'h1234;
    PA = 32'h55; PB = 32'h66; PD = 32'h77; ex_result = 32'h88;
    mem_dest = 4'd7; mem_wr_en = 1; mem_result = 32'h99; wb_dest = 4'd3; wb_wr_en = 1; wb_data = 32'haa;
    tick(); tick();
    check("rst_valid", ex_valid, 0);
    check("rst_a", ex_a, 0);
    check("rst_ctrl", ex_ctrl, 0);
    check("rst_wr_load", {ex_wr_en, ex_is_load, ex_dest}, 0);
    check("rst_cnt", stall_cnt, 0);
    check("rst_stall", stall, 0);
    check("sa_comb", SA, 7);
    RST = 0; id_use_b = 0; id_use_d = 0; id_is_load = 0; mem_wr_en = 0; wb_wr_en = 0;
    id_sa = 4'd1; PA = 32'd3; id_ctrl = 16'habcd; id_dest = 4'd5;
    tick();
    check("nohaz_a", ex_a, 3);
    check("nohaz_valid", ex_valid, 1);
    check("nohaz_ctrl", ex_ctrl, 16'habcd);
    check("nohaz_dest_wr", {ex_dest, ex_wr_en, ex_is_load}, {4'd5, 1'b1, 1'b0});
    id_dest = 4'd2;
    tick();
    ex_result = 32'd90; mem_dest = 4'd2; mem_wr_en = 1; mem_result = 32'd7;
    id_sb = 4'd2; use_b_on(); PB = 32'd0; id_dest = 4'd0; id_wr_en = 0;
    tick();
    check("ex_beats_mem", ex_b, 90);
    tick();
    check("mem_fwd", ex_b, 7);
    id_dest = 4'd4; id_wr_en = 1; id_is_load = 1; id_sa = 4'd0; id_sb = 4'd0; id_use_a = 0; id_use_b = 0; mem_wr_en = 0;
    tick();
    id_dest = 4'd6; id_is_load = 0; id_sa = 4'd4; id_use_a = 1; PA = 32'd0;
    #1;
    check("lu_stall", stall, 1);
    tick();
    check("lu_bubble", ex_valid, 0);
    check("lu_cnt", stall_cnt, 1);
    check("lu_one_cycle", stall, 0);
    mem_dest = 4'd4; mem_wr_en = 1; mem_result = 32'd17;
    tick();
    check("lu_mem_a", ex_a, 17);
    check("lu_valid", ex_valid, 1);
    mem_wr_en = 0; id_sa = 4'd10; PA = 32'd9; wb_wr_en = 1; wb_dest = 4'd10; wb_data = 32'd16;
    tick();
    check("wb_fwd", ex_a, 16);
    wb_wr_en = 0; id_sa = 4'd0; id_dest = 4'd3; id_is_load = 1;
    tick();
    id_sa = 4'd3; id_is_load = 0; id_dest = 4'd1; id_sb = 4'd3; id_use_b = 0;
    #1;
    check("flush_pre_stall", stall, 1);
    flush = 1;
    #1;
    check("flush_stall", stall, 0);
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_cnt", stall_cnt, 1);
    flush = 0; id_use_a = 0; id_sa = 4'd3;
    id_dest = 4'd3; id_is_load = 1;
    tick();
    id_is_load = 0; id_sb = 4'd3; id_use_b = 0; id_sa = 4'd0;
    #1;
    check("unused_no_stall", stall, 0);
    id_sa = 4'd0; id_dest = 4'd15; id_is_load = 0; id_wr_en = 1;
    tick();
    id_sa = 4'd15; id_use_a = 1; ex_result = 32'd35; PA = 32'd100; id_dest = 4'd0;
    tick();
    check("r15_no_fwd", ex_a, 100);
    id_sa = 4'd0; id_dest = 4'd15; id_is_load = 1;
    tick();
    id_sa = 4'd15; id_is_load = 0;
    #1;
    check("r15_no_stall", stall, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic use_b_on();
    id_use_b = 1;
  endtask
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode/operand-fetch stage directly downstream of the 16x32 register file.
- Drives the file's read selects (SA/SB/SD) and consumes its read ports (PA/PB/PD).
- Resolves RAW hazards by forwarding from EX, MEM and WB. Detects load-use hazards and stalls for one cycle by inserting a bubble.
- Registers operands and control into the ID/EX pipeline register feeding the ALU.

Parameters:
- CTRL_W, 16, width of the opaque decoded control bundle carried to EX.
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous reset, active-high.
- id_valid  input  1  decode slot holds a real instruction.
- id_sa, id_sb, id_sd  input  4 each  source register numbers.
- id_use_a, id_use_b, id_use_d  input  1 each  the matching source is actually read.
- id_dest  input  4  destination register number.
- id_wr_en  input  1  instruction writes id_dest.
- id_is_load  input  1  instruction is a memory load.
- id_ctrl  input  CTRL_W  decoded control bundle.
- SA, SB, SD  output  4 each  register-file read selects; combinational copies of id_sa/id_sb/id_sd.
- PA, PB, PD  input  32 each  register-file read data.
- ex_result  input  32  ALU result of the instruction currently in EX.
- mem_dest  input  4  MEM-stage destination register.
- mem_wr_en  input  1  MEM-stage write enable.
- mem_result  input  32  MEM-stage result.
- wb_dest  input  4  write-back destination; the same net drives the file's C.
- wb_wr_en  input  1  write-back enable; the same net drives the file's RFLd.
- wb_data  input  32  write-back data; the same net drives the file's PW.
- flush  input  1  kill the instruction in decode (branch taken).
- stall  output  1  hold IF and ID this cycle.
- ex_valid  output  1  registered: EX slot is valid.
- ex_a, ex_b, ex_d  output  32 each  registered forwarded operands.
- ex_dest  output  4  registered destination.
- ex_wr_en  output  1  registered write enable.
- ex_is_load  output  1  registered load flag.
- ex_ctrl  output  CTRL_W  registered control bundle.
- stall_cnt  output  CNT_W  registered count of stall cycles.

Behaviour:
- Reset: synchronous, active-high, sampled on posedge CLK.
  - On reset every registered output is 0: ex_valid, ex_a/b/d, ex_dest, ex_wr_en, ex_is_load, ex_ctrl, stall_cnt.
  - RST has priority over flush and stall.
- Read selects: SA/SB/SD are purely combinational copies of id_sa/id_sb/id_sd, so PA/PB/PD return within the same cycle.
- Forward select, per source X in {a, b, d}, evaluated in priority order:
  1. Source 15 (PC) is never forwarded; the value comes from PA/PB/PD as-is.
  2. EX: ex_valid && ex_wr_en && !ex_is_load && ex_dest==src -> ex_result.
  3. MEM: mem_wr_en && mem_dest==src -> mem_result.
  4. WB: wb_wr_en && wb_dest==src -> wb_data. This covers the write-before-read gap, because the file updates only on the edge.
  5. Otherwise: PA/PB/PD.
  - Unused sources (id_use_X=0) still get forwarded data but never cause a stall.
- Load-use stall (combinational):
  - stall = id_valid && !flush && ex_valid && ex_is_load && ex_wr_en && ex_dest!=15 && (some used source == ex_dest).
  - Exactly one stall cycle per hazard: the next cycle EX holds the bubble, and the load has reached MEM to be forwarded.
- ID/EX register update at posedge, by priority:
  - RST -> all zero.
  - flush -> ex_valid=0, ex_wr_en=0, ex_is_load=0; data fields are don't-care but implemented as 0.
  - stall -> bubble inserted: ex_valid=0, ex_wr_en=0, ex_is_load=0.
  - otherwise -> ex_valid=id_valid. All fields load from the forwarded operands and the id_* inputs. ex_wr_en and ex_is_load are ANDed with id_valid.
- Simultaneous flush and hazard: flush wins and stall=0, so the killed instruction never stalls the front end.
- stall_cnt increments by 1 on each cycle with stall=1. It saturates at 2^CNT_W-1 with no wrap and clears only on RST.
- Latency: one cycle from decode inputs to ex_* outputs; zero extra cycles without a hazard.

Test Plan:
- Reset: RST=1 for 2 cycles with arbitrary inputs -> all ex_* outputs and stall_cnt equal 0, stall=0. SA follows id_sa=4'd7 combinationally.
- No hazard:
  - Stimulus: PA=32'd3 for id_sa=1 with use_a=1; no forwarding write enables active.
  - Response: next edge ex_a=3 and ex_valid=1.
- EX forwarding beats MEM forwarding:
  - Stimulus: EX writes R2 non-load with ex_result=32'd90; mem_dest=2, mem_result=32'd7; PB=32'd0 for id_sb=2.
  - Response: ex_b=90.
- Load-use hazard:
  - Stimulus: EX holds a load to R4 while id_sa=4 with use_a=1.
  - Response: stall=1 for exactly one cycle, a bubble appears (ex_valid=0), stall_cnt goes 0->1.
  - Next cycle: mem_dest=4 with mem_result=32'd17 gives ex_a=17.
- WB same-cycle forwarding:
  - Stimulus: wb_wr_en=1, wb_dest=10, wb_data=32'd16 while PA still returns the old value 32'd9 for id_sa=10.
  - Response: ex_a=16.
- Flush and R15 rules:
  - flush=1 together with a load-use hazard -> stall=0 and ex_valid=0 next edge.
  - id_sa=15 with EX writing R15 with ex_result=32'd35 and PA=32'd100 -> ex_a=100.
